// File: rtl/rom_controller_pkg.sv
// rom_controller_pkg: shared state encoding, mode constants and default flash timing for the ROM read path.
package rom_controller_pkg;
   typedef enum logic [1:0] {IDLE, RD_WORD, RD_HI, RD_LO} state_t;
   localparam logic BYTE_MODE = 1'b1;
   localparam logic WORD_MODE = 1'b0;
   localparam int DEF_ACCESS_CYCLES = 6;
endpackage

// File: rtl/rom_controller_access_timer.sv
// access_timer: loadable down-counter with a zero flag, used to hold each flash read for a fixed number of cycles.
module access_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] value,
   output logic         zero
);
   logic [W-1:0] count;
   always_ff @(posedge clk or negedge rst)
      if (!rst) count <= '0;
      else count <= load ? value : dec ? count - 1'b1 : count;
   assign zero = count == '0;
endmodule

// File: rtl/rom_controller.sv
// rom_controller: accepts word/byte load requests and runs timed asynchronous reads on a parallel flash.
module rom_controller
   import rom_controller_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int ROM_ADDR      = 24,
   parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ROM_ADDR-1:0] rom_addr,
   input  logic                load_rom,
   input  logic                byte_mode,
   output logic [WIDTH-1:0]    src_data,
   output logic                ready,
   output logic [ROM_ADDR-1:0] flash_addr,
   output logic                flash_ce_n,
   output logic                flash_oe_n,
   output logic                flash_byte_n,
   input  logic [WIDTH-1:0]    flash_data
);
   localparam int CW = $clog2(ACCESS_CYCLES) + 1;
   state_t state, state_nx;
   logic zero, tload, tdec;
   logic [ROM_ADDR-1:0] addr_nx;
   access_timer #(.W(CW)) u_timer (
      .clk(clk), .rst(rst), .load(tload), .dec(tdec),
      .value(CW'(ACCESS_CYCLES - 1)), .zero(zero)
   );
   assign tdec = state != IDLE && !zero;
   // Address bit 0 is dropped on accept; the second byte read just sets it.
   always_comb begin
      state_nx = state;
      tload = 1'b0;
      addr_nx = flash_addr;
      case (state)
         IDLE: if (load_rom) begin
            state_nx = byte_mode == BYTE_MODE ? RD_HI : RD_WORD;
            tload = 1'b1;
            addr_nx = rom_addr & ~ROM_ADDR'(1);
         end
         RD_HI: if (zero) begin
            state_nx = RD_LO;
            tload = 1'b1;
            addr_nx = flash_addr | ROM_ADDR'(1);
         end
         RD_WORD, RD_LO: state_nx = zero ? IDLE : state;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         src_data <= '0;
         ready <= 1'b0;
         flash_addr <= '0;
         flash_ce_n <= 1'b1;
         flash_oe_n <= 1'b1;
         flash_byte_n <= 1'b1;
      end else begin
         state <= state_nx;
         flash_addr <= addr_nx;
         flash_ce_n <= state_nx == IDLE;
         flash_oe_n <= state_nx == IDLE;
         flash_byte_n <= !(state_nx == RD_HI || state_nx == RD_LO);
         ready <= zero && (state == RD_WORD || state == RD_LO);
         if (zero && state == RD_WORD) src_data <= flash_data;
         if (zero && state == RD_HI) src_data[WIDTH-1:WIDTH/2] <= flash_data[WIDTH/2-1:0];
         if (zero && state == RD_LO) src_data[WIDTH/2-1:0] <= flash_data[WIDTH/2-1:0];
      end
endmodule

// File: tb/tb_rom_controller.sv
// tb_rom_controller: scoreboard bench for rom_controller with a flash model, at 6-cycle and 1-cycle access timing.
module tb_rom_controller;
   typedef struct {logic [15:0] data; int cyc;} exp_t;
   logic clk = 0, rst = 0, load_rom = 0, byte_mode = 0;
   logic [23:0] rom_addr = '0, flash_addr;
   logic [15:0] src_data, flash_data;
   logic ready, flash_ce_n, flash_oe_n, flash_byte_n;
   logic load1 = 0;
   logic [23:0] addr1 = '0, flash_addr1;
   logic [15:0] src_data1, flash_data1;
   logic ready1, ce_n1, oe_n1, byte_n1;
   int cyc = 0, n_cmp = 0, n_err = 0, ce_cnt = 0;
   exp_t q[$], q1[$];
   exp_t e0, e1;
   logic [15:0] b2b [4] = '{16'h1011, 16'h1213, 16'h1415, 16'h1617};

   rom_controller #(.ACCESS_CYCLES(6)) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .load_rom(load_rom), .byte_mode(byte_mode),
      .src_data(src_data), .ready(ready), .flash_addr(flash_addr), .flash_ce_n(flash_ce_n),
      .flash_oe_n(flash_oe_n), .flash_byte_n(flash_byte_n), .flash_data(flash_data));
   rom_controller #(.ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .rom_addr(addr1), .load_rom(load1), .byte_mode(1'b0),
      .src_data(src_data1), .ready(ready1), .flash_addr(flash_addr1), .flash_ce_n(ce_n1),
      .flash_oe_n(oe_n1), .flash_byte_n(byte_n1), .flash_data(flash_data1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Flash model: x16 words, or x8 bytes on [7:0] with junk on the upper lane.
   function automatic logic [7:0] byte_at(logic [23:0] a);
      return a == 24'h40 ? 8'h12 : a == 24'h41 ? 8'h34 : a[7:0] + 8'h10;
   endfunction
   function automatic logic [15:0] word_at(logic [23:0] a);
      return a == 24'h102 ? 16'hBEEF : {8'hC3, a[7:0]};
   endfunction
   assign flash_data  = flash_byte_n ? word_at(flash_addr) : {8'hEE, byte_at(flash_addr)};
   assign flash_data1 = byte_n1 ? word_at(flash_addr1) : {8'hEE, byte_at(flash_addr1)};

   task automatic check(string n, logic [31:0] a, logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (!flash_ce_n) ce_cnt++;
      if (ready) begin
         if (q.size() == 0) check("unexpected_ready", 1, 0);
         else begin
            e0 = q.pop_front();
            check("src_data", src_data, e0.data);
            check("ready_cycle", cyc, e0.cyc);
         end
      end
      if (ready1) begin
         if (q1.size() == 0) check("unexpected_ready1", 1, 0);
         else begin
            e1 = q1.pop_front();
            check("src_data1", src_data1, e1.data);
            check("ready_cycle1", cyc, e1.cyc);
         end
      end
   end

   task automatic drive(logic [23:0] a, logic m, logic [15:0] d, int lat, bit push);
      rom_addr = a;
      byte_mode = m;
      load_rom = 1;
      if (push) q.push_back('{d, cyc + 1 + lat});
      @(negedge clk);
      load_rom = 0;
   endtask

   task automatic start(logic [23:0] a, logic m, logic [15:0] d, int lat, bit push);
      @(negedge clk);
      drive(a, m, d, lat, push);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && (q.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      if (q.size() != 0 || q1.size() != 0) begin
         check("timeout_pending", q.size() + q1.size(), 0);
         q.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ce_n", flash_ce_n, 1);
      check("rst_oe_n", flash_oe_n, 1);
      check("rst_byte_n", flash_byte_n, 1);
      check("rst_addr", flash_addr, 0);
      check("rst_src", src_data, 0);
      check("rst_ready", ready, 0);
      rst = 1;
      // word read
      ce_cnt = 0;
      start(24'h000102, 0, 16'hBEEF, 6, 1);
      check("w_byte_n", flash_byte_n, 1);
      check("w_addr", flash_addr, 24'h000102);
      check("w_ce_n", flash_ce_n, 0);
      check("w_oe_n", flash_oe_n, 0);
      wait_idle();
      check("w_ce_cycles", ce_cnt, 6);
      // byte read, odd address
      ce_cnt = 0;
      start(24'h000041, 1, 16'h1234, 12, 1);
      check("b_byte_n", flash_byte_n, 0);
      check("b_addr_hi", flash_addr, 24'h000040);
      repeat (6) @(negedge clk);
      check("b_addr_lo", flash_addr, 24'h000041);
      check("b_ce_n_held", flash_ce_n, 0);
      check("b_src_hi", src_data[15:8], 8'h12);
      wait_idle();
      check("b_ce_cycles", ce_cnt, 12);
      // request while busy is dropped
      ce_cnt = 0;
      start(24'h000004, 0, 16'hC304, 6, 1);
      repeat (2) @(negedge clk);
      drive(24'h000200, 0, 16'h0, 6, 0);
      wait_idle();
      repeat (10) @(negedge clk);
      check("busy_ce_cycles", ce_cnt, 6);
      // back-to-back byte streaming, load raised in each ready cycle
      ce_cnt = 0;
      start(24'h000000, 1, b2b[0], 12, 1);
      for (int k = 1; k < 4; k++) begin
         for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
         if (!ready) check("b2b_ready_seen", 0, 1);
         drive(24'(2 * k), 1, b2b[k], 12, 1);
      end
      wait_idle();
      check("b2b_ce_cycles", ce_cnt, 48);
      // reset two cycles into the second byte read
      start(24'h000010, 1, 16'h0, 12, 0);
      repeat (8) @(negedge clk);
      check("mid_src_hi", src_data[15:8], 8'h20);
      check("mid_ce_n", flash_ce_n, 0);
      #1 rst = 0;
      #1;
      check("arst_ce_n", flash_ce_n, 1);
      check("arst_oe_n", flash_oe_n, 1);
      check("arst_ready", ready, 0);
      check("arst_src", src_data, 0);
      check("arst_byte_n", flash_byte_n, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      repeat (20) @(negedge clk);
      start(24'h000102, 0, 16'hBEEF, 6, 1);
      wait_idle();
      // single-cycle access timing
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         addr1 = k == 0 ? 24'h000102 : 24'h000007;
         load1 = 1;
         q1.push_back('{k == 0 ? 16'hBEEF : 16'hC306, cyc + 2});
         @(negedge clk);
         load1 = 0;
         check("min_addr", flash_addr1, k == 0 ? 24'h000102 : 24'h000006);
         wait_idle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
